fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//   Instruction queue between fetch and decoder. Buffers fetched instruction
//   words with their PC and branch-predictor metadata, and presents the oldest
//   entry to the decoder's valid/i_instr/i_pc/guesses_branch/prediction inputs.
//   Absorbs fetch/decode rate mismatch and back-end stalls. Drops all contents
//   on a redirect, driven by decoder o_branch_inconsistency or a back-end flush.
// PARAMETERS
//   DEPTH       8             entries; power of two, >= 2
//   ADDR_WIDTH  `ADDR_WIDTH   PC / prediction width
// PORTS
//   clk               in   1           clock, all state on rising edge
//   n_rst             in   1           async active-low reset
//   i_valid           in   1           fetch presents an entry this cycle
//   o_ready           out  1           buffer can accept an entry (not full)
//   i_instr           in   32          fetched instruction word
//   i_pc              in   ADDR_WIDTH  PC of i_instr
//   i_guesses_branch  in   1           predictor redirected after this instr
//   i_prediction      in   ADDR_WIDTH  predicted next PC
//   o_valid           out  1           head entry valid -> decoder valid
//   i_dec_ready       in   1           decoder consumes head this cycle
//   o_instr           out  32         head instruction word
//   o_pc              out  ADDR_WIDTH  head PC
//   o_guesses_branch  out  1           head predictor flag
//   o_prediction      out  ADDR_WIDTH  head predicted next PC
//   i_flush           in   1           discard all entries (redirect)
//   o_count           out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//   Reset (n_rst=0, async): wr_ptr=rd_ptr=0, count=0 -> o_valid=0, o_ready=1,
//     o_count=0. o_instr=32'h00000013, o_pc/o_prediction=0, o_guesses_branch=0.
//     Storage array itself is not reset. Reset mid-stream discards all entries.
//   Storage: circular array of {instr, pc, guesses_branch, prediction}.
//     Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   push = i_valid & o_ready & ~i_flush.  pop = o_valid & i_dec_ready & ~i_flush.
//   o_ready = (count != DEPTH). It is registered-state only and independent of
//     i_dec_ready: no push when full, even if a pop occurs the same cycle.
//   o_valid = (count != 0). Head fields are a combinational read of
//     mem[rd_ptr]. When empty, o_instr=32'h00000013 (NOP) and other head
//     fields are 0.
//   Latency: an entry pushed in cycle N is visible at the head no earlier than
//     N+1. There is no bypass from input to output.
//   Push and pop in the same cycle: both pointers advance, count unchanged.
//   Flush: at the next edge wr_ptr=rd_ptr=0 and count=0. Any push or pop in the
//     flush cycle is ignored, and o_valid=0 from the following cycle. Flush has
//     priority over push and pop.
//   Head stability: while o_valid=1 and i_dec_ready=0, all head outputs hold
//     constant.
//   Order: strictly FIFO. Entry metadata travels unmodified.
//   Assertions (sim): no push when count==DEPTH, no pop when count==0,
//     count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when pointers
//     are equal and the buffer is full.
// TESTING
//   1 Reset: n_rst=0 mid-run with 5 entries -> immediately o_valid=0,
//     o_count=0, o_ready=1, o_instr=32'h00000013.
//   2 Fill: push 8 entries (pc 0x100,0x104..0x11C, i_dec_ready=0) ->
//     o_ready=0 after the 8th; 9th i_valid ignored; o_count=8.
//   3 Drain order: i_dec_ready=1 from full -> o_pc sequence 0x100..0x11C on
//     8 consecutive cycles, then o_valid=0.
//   4 Simultaneous push/pop at count=3 for 20 cycles -> o_count stays 3;
//     pointers wrap; output order preserved.
//   5 Flush with push+pop same cycle at count=4 -> next cycle o_count=0,
//     o_valid=0; the pushed entry never appears at the output.
//   6 Metadata: push instr 32'h0080006F, pc 0x200, guesses_branch=1,
//     prediction 0x208 -> head shows identical values; held stable under
//     3 cycles of i_dec_ready=0.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decoder head side, flush and occupancy.
// The slave modport is the buffer's view; the master modport is the fetch/decode environment's view.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface fetch_buffer_if #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  i_valid;
  logic                  o_ready;
  logic [31:0]           i_instr;
  logic [ADDR_WIDTH-1:0] i_pc;
  logic                  i_guesses_branch;
  logic [ADDR_WIDTH-1:0] i_prediction;
  logic                  o_valid;
  logic                  i_dec_ready;
  logic [31:0]           o_instr;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_guesses_branch;
  logic [ADDR_WIDTH-1:0] o_prediction;
  logic                  i_flush;
  logic [CNT_W-1:0]      o_count;

  modport slave (
    input  i_valid, i_instr, i_pc, i_guesses_branch, i_prediction, i_dec_ready, i_flush,
    output o_ready, o_valid, o_instr, o_pc, o_guesses_branch, o_prediction, o_count
  );

  modport master (
    output i_valid, i_instr, i_pc, i_guesses_branch, i_prediction, i_dec_ready, i_flush,
    input  o_ready, o_valid, o_instr, o_pc, o_guesses_branch, o_prediction, o_count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and decode; head visible one cycle after push, no bypass.
// o_ready depends only on occupancy (no push when full, even with a same-cycle pop); flush wins over push/pop.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input logic           clk,
  input logic           n_rst,
  fetch_buffer_if.slave bus
);
  localparam int          PTR_W = $clog2(DEPTH);
  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  guesses_branch;
    logic [ADDR_WIDTH-1:0] prediction;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.i_valid & ~full & ~bus.i_flush;
  assign pop   = ~empty & bus.i_dec_ready & ~bus.i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; o_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{instr:          bus.i_instr,
                         pc:             bus.i_pc,
                         guesses_branch: bus.i_guesses_branch,
                         prediction:     bus.i_prediction};
    end
  end

  always_comb begin
    head       = '0;
    head.instr = NOP;
    if (!empty) head = mem[rd_ptr_q];
  end

  assign bus.o_ready          = ~full;
  assign bus.o_valid          = ~empty;
  assign bus.o_instr          = head.instr;
  assign bus.o_pc             = head.pc;
  assign bus.o_guesses_branch = head.guesses_branch;
  assign bus.o_prediction     = head.prediction;
  assign bus.o_count          = count_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (PTR_W'(count_q) == PTR_W'(wr_ptr_q - rd_ptr_q));
      assert (!(full && (wr_ptr_q != rd_ptr_q)));
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: constant vector table, directed corner sequences, then random traffic
// compared against a queue-based model of the buffer's contents.
module tb_fetch_buffer;
  localparam int          DEPTH = 8;
  localparam int          AW    = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic          valid;
    logic          ready;
    logic [3:0]    count;
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          gb;
    logic [AW-1:0] pred;
  } obs_t;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          gb;
    logic [AW-1:0] pred;
  } ent_t;

  typedef struct {
    logic          v;
    logic [AW-1:0] pc;
    logic          dr;
    logic          ev;
    logic          er;
    int            ec;
    logic [AW-1:0] epc;
  } vec_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  vec_t tbl[$];

  fetch_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tinstr(input logic [AW-1:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic obs_t mk(input logic v, input logic r, input int c, input logic [31:0] instr,
                              input logic [AW-1:0] pc, input logic gb, input logic [AW-1:0] pred);
    obs_t o;
    o.valid = v; o.ready = r; o.count = 4'(c);
    o.instr = instr; o.pc = pc; o.gb = gb; o.pred = pred;
    return o;
  endfunction

  // Expected outputs of a table entry built from its PC alone.
  function automatic obs_t mk_pc(input logic v, input logic r, input int c, input logic [AW-1:0] pc);
    if (!v) return mk(1'b0, r, c, NOP, '0, 1'b0, '0);
    return mk(1'b1, r, c, tinstr(pc), pc, pc[2], pc + 8);
  endfunction

  function automatic obs_t model();
    if (q.size() == 0) return mk(1'b0, 1'b1, 0, NOP, '0, 1'b0, '0);
    return mk(1'b1, q.size() != DEPTH, q.size(), q[0].instr, q[0].pc, q[0].gb, q[0].pred);
  endfunction

  function automatic obs_t actual();
    return mk(bus.o_valid, bus.o_ready, int'(bus.o_count), bus.o_instr, bus.o_pc,
              bus.o_guesses_branch, bus.o_prediction);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b r=%0b cnt=%0d instr=%h pc=%h gb=%0b pred=%h | want v=%0b r=%0b cnt=%0d instr=%h pc=%h gb=%0b pred=%h",
               name, act.valid, act.ready, act.count, act.instr, act.pc, act.gb, act.pred,
               exp.valid, exp.ready, exp.count, exp.instr, exp.pc, exp.gb, exp.pred);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [AW-1:0] pc,
                       input logic gb, input logic [AW-1:0] pred, input logic dr, input logic fl);
    bus.i_valid          = v;
    bus.i_instr          = instr;
    bus.i_pc             = pc;
    bus.i_guesses_branch = gb;
    bus.i_prediction     = pred;
    bus.i_dec_ready      = dr;
    bus.i_flush          = fl;
  endtask

  task automatic drive_pc(input logic v, input logic [AW-1:0] pc, input logic dr, input logic fl);
    drive(v, tinstr(pc), pc, pc[2], pc + 8, dr, fl);
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    bit   do_push, do_pop;
    ent_t e;
    do_push = bus.i_valid && (q.size() != DEPTH) && !bus.i_flush;
    do_pop  = (q.size() != 0) && bus.i_dec_ready && !bus.i_flush;
    e = '{instr: bus.i_instr, pc: bus.i_pc, gb: bus.i_guesses_branch, pred: bus.i_prediction};
    if (bus.i_flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_pc(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", mk(1'b0, 1'b1, 0, NOP, '0, 1'b0, '0));
    n_rst = 1'b1;

    // Fill to full (ninth push refused), drain in order, end empty.
    for (int i = 0; i <= DEPTH; i++)
      tbl.push_back('{v: 1'b1, pc: AW'(32'h100 + 4 * i), dr: 1'b0,
                      ev: (i != 0), er: (i != DEPTH), ec: i, epc: (i != 0) ? AW'(32'h100) : '0});
    for (int j = 0; j < DEPTH; j++)
      tbl.push_back('{v: 1'b0, pc: '0, dr: 1'b1,
                      ev: 1'b1, er: (j != 0), ec: DEPTH - j, epc: AW'(32'h100 + 4 * j)});
    tbl.push_back('{v: 1'b0, pc: '0, dr: 1'b1, ev: 1'b0, er: 1'b1, ec: 0, epc: '0});

    for (int k = 0; k < tbl.size(); k++) begin
      drive_pc(tbl[k].v, tbl[k].pc, tbl[k].dr, 1'b0);
      check($sformatf("table[%0d]", k), mk_pc(tbl[k].ev, tbl[k].er, tbl[k].ec, tbl[k].epc));
      tick();
    end

    // Steady push+pop at occupancy 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      drive_pc(1'b1, AW'(32'h300 + 4 * i), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive_pc(1'b1, AW'(32'h30C + 4 * k), 1'b1, 1'b0);
      check($sformatf("pushpop[%0d]", k), mk_pc(1'b1, 1'b1, 3, AW'(32'h300 + 4 * k)));
      tick();
    end
    drive_pc(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Flush at occupancy 4 with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      drive_pc(1'b1, AW'(32'h400 + 4 * i), 1'b0, 1'b0);
      tick();
    end
    drive_pc(1'b1, AW'(32'h4F0), 1'b1, 1'b1);
    check("flush_pre", mk_pc(1'b1, 1'b1, 4, AW'(32'h400)));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive_pc(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("flush_post[%0d]", k), mk_pc(1'b0, 1'b1, 0, '0));
      tick();
    end
    drive_pc(1'b1, AW'(32'h500), 1'b0, 1'b0);
    tick();
    drive_pc(1'b0, '0, 1'b1, 1'b0);
    check("after_flush_push", mk_pc(1'b1, 1'b1, 1, AW'(32'h500)));
    tick();

    // Metadata pass-through, no same-cycle bypass, head held while stalled.
    drive(1'b1, 32'h0080006F, AW'(32'h200), 1'b1, AW'(32'h208), 1'b0, 1'b0);
    check("meta_no_bypass", mk(1'b0, 1'b1, 0, NOP, '0, 1'b0, '0));
    tick();
    drive_pc(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("meta_hold[%0d]", k), mk(1'b1, 1'b1, 1, 32'h0080006F, AW'(32'h200), 1'b1, AW'(32'h208)));
      tick();
    end
    drive_pc(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("meta_popped", mk(1'b0, 1'b1, 0, NOP, '0, 1'b0, '0));

    // Asynchronous reset with 5 entries queued.
    for (int i = 0; i < 5; i++) begin
      drive_pc(1'b1, AW'(32'h600 + 4 * i), 1'b0, 1'b0);
      tick();
    end
    drive_pc(1'b0, '0, 1'b0, 1'b0);
    check("pre_reset", mk_pc(1'b1, 1'b1, 5, AW'(32'h600)));
    #3;
    n_rst = 1'b0;
    #1;
    check("async_reset", mk(1'b0, 1'b1, 0, NOP, '0, 1'b0, '0));
    q.delete();
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", mk(1'b0, 1'b1, 0, NOP, '0, 1'b0, '0));

    // Random traffic against the queue model.
    for (int k = 0; k < 800; k++) begin
      drive($urandom_range(9) < 7, $urandom, AW'($urandom), 1'($urandom), AW'($urandom),
            $urandom_range(9) < 5, $urandom_range(39) == 0);
      check($sformatf("rand[%0d]", k), model());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
